// File: rtl/countdown_ctrl_pkg.sv
// Shared types and constants for the MM:SS countdown controller.
//   state_t       controller state encoding
//   *_MAX         highest legal value of each BCD digit of MM:SS
//   MMSS_ZERO     00:00
//   MMSS_ONE      00:01, the last count before the alarm
package countdown_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] M10_MAX = 4'd9;
  localparam logic [3:0] M1_MAX  = 4'd9;
  localparam logic [3:0] S10_MAX = 4'd5;
  localparam logic [3:0] S1_MAX  = 4'd9;

  localparam logic [15:0] MMSS_ZERO = 16'h0000;
  localparam logic [15:0] MMSS_ONE  = 16'h0001;

endpackage

// File: rtl/countdown_ctrl_if.sv
// Button/tick inputs and display outputs of the countdown controller.
//   CE, TICK, BTN_*            : controller inputs (master drives)
//   DIGITS, BLINK, RUNNING, DONE : registered controller outputs (slave drives)
interface countdown_ctrl_if;
  logic        CE;
  logic        TICK;
  logic        BTN_START;
  logic        BTN_STOP;
  logic        BTN_UP;
  logic        BTN_DOWN;
  logic [15:0] DIGITS;
  logic        BLINK;
  logic        RUNNING;
  logic        DONE;

  modport master (
    output CE, TICK, BTN_START, BTN_STOP, BTN_UP, BTN_DOWN,
    input  DIGITS, BLINK, RUNNING, DONE
  );

  modport slave (
    input  CE, TICK, BTN_START, BTN_STOP, BTN_UP, BTN_DOWN,
    output DIGITS, BLINK, RUNNING, DONE
  );
endinterface

// File: rtl/mmss_bcd_cnt.sv
// 16-bit BCD MM:SS register {M10,M1,S10,S1} with load, +1 s / -1 s and wrap
// (99:59 <-> 00:00).  All arithmetic is per digit.
//   CLK, CLR   clock, synchronous active-high reset to RESET_VAL
//   en         update enable (clock enable of the owner)
//   load       load load_val (wins over inc/dec)
//   inc, dec   step +1 s / -1 s; both together means no change
//   q          current value
//   q_nxt      value q takes at the next enabled edge
//   zero       q == 00:00
import countdown_ctrl_pkg::*;

module mmss_bcd_cnt #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        inc,
  input  logic        dec,
  output logic [15:0] q,
  output logic [15:0] q_nxt,
  output logic        zero
);

  logic [15:0] inc_v;
  logic [15:0] dec_v;

  always_comb begin
    inc_v = q;
    if (q[3:0] != S1_MAX) begin
      inc_v[3:0] = q[3:0] + 4'd1;
    end else begin
      inc_v[3:0] = 4'd0;
      if (q[7:4] != S10_MAX) begin
        inc_v[7:4] = q[7:4] + 4'd1;
      end else begin
        inc_v[7:4] = 4'd0;
        if (q[11:8] != M1_MAX) begin
          inc_v[11:8] = q[11:8] + 4'd1;
        end else begin
          inc_v[11:8]  = 4'd0;
          inc_v[15:12] = (q[15:12] != M10_MAX) ? q[15:12] + 4'd1 : 4'd0;
        end
      end
    end
  end

  always_comb begin
    dec_v = q;
    if (q[3:0] != 4'd0) begin
      dec_v[3:0] = q[3:0] - 4'd1;
    end else begin
      dec_v[3:0] = S1_MAX;
      if (q[7:4] != 4'd0) begin
        dec_v[7:4] = q[7:4] - 4'd1;
      end else begin
        dec_v[7:4] = S10_MAX;
        if (q[11:8] != 4'd0) begin
          dec_v[11:8] = q[11:8] - 4'd1;
        end else begin
          dec_v[11:8]  = M1_MAX;
          dec_v[15:12] = (q[15:12] != 4'd0) ? q[15:12] - 4'd1 : M10_MAX;
        end
      end
    end
  end

  always_comb begin
    q_nxt = q;
    if (load)              q_nxt = load_val;
    else if (inc && !dec)  q_nxt = inc_v;
    else if (dec && !inc)  q_nxt = dec_v;
  end

  always_ff @(posedge CLK) begin
    if (CLR)     q <= RESET_VAL;
    else if (en) q <= q_nxt;
  end

  assign zero = (q == MMSS_ZERO);

endmodule

// File: rtl/countdown_ctrl.sv
// MM:SS countdown timer controller with preset adjust, pause and alarm.
//   CLK, CLR   clock, synchronous active-high reset
//   bus        countdown_ctrl_if.slave: CE/TICK/buttons in, registered
//              DIGITS/BLINK/RUNNING/DONE out
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | show preset, UP/DOWN adjust it, START begins countdown
// ST_RUN   | counter decrements on TICK
// ST_PAUSE | counter frozen, display blinks
// ST_ALARM | shows 00:00, DONE=1, leaves on button or ALARM_TICKS TICKs
import countdown_ctrl_pkg::*;

module countdown_ctrl #(
  parameter int          ALARM_TICKS    = 10,
  parameter logic [15:0] PRESET_DEFAULT = 16'h0100
) (
  input logic              CLK,
  input logic              CLR,
  countdown_ctrl_if.slave  bus
);

  localparam int AW = $clog2(ALARM_TICKS + 1);

  state_t state_q, state_nxt;
  logic [AW-1:0] alm_q;
  logic          alm_load, alm_dec;
  logic          blink_nxt;
  logic [15:0]   digits_nxt;

  logic [15:0] pre_q, pre_nxt, cnt_q, cnt_nxt, cnt_load_val;
  logic        pre_zero, cnt_zero;
  logic        pre_inc, pre_dec, cnt_load, cnt_dec;

  mmss_bcd_cnt #(.RESET_VAL(PRESET_DEFAULT)) u_preset (
    .CLK(CLK), .CLR(CLR), .en(bus.CE),
    .load(1'b0), .load_val(MMSS_ZERO),
    .inc(pre_inc), .dec(pre_dec),
    .q(pre_q), .q_nxt(pre_nxt), .zero(pre_zero)
  );

  mmss_bcd_cnt #(.RESET_VAL(MMSS_ZERO)) u_count (
    .CLK(CLK), .CLR(CLR), .en(bus.CE),
    .load(cnt_load), .load_val(cnt_load_val),
    .inc(1'b0), .dec(cnt_dec),
    .q(cnt_q), .q_nxt(cnt_nxt), .zero(cnt_zero)
  );

  always_comb begin
    state_nxt    = state_q;
    pre_inc      = 1'b0;
    pre_dec      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = MMSS_ZERO;
    cnt_dec      = 1'b0;
    alm_load     = 1'b0;
    alm_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // STOP outranks START even though STOP alone does nothing here.
        if (bus.BTN_START && !bus.BTN_STOP && !pre_zero) begin
          state_nxt    = ST_RUN;
          cnt_load     = 1'b1;
          cnt_load_val = pre_q;
        end else begin
          pre_inc = bus.BTN_UP;
          pre_dec = bus.BTN_DOWN;
        end
      end
      ST_RUN: begin
        if (bus.BTN_STOP) begin
          state_nxt = ST_IDLE;
          cnt_load  = 1'b1;
        end else if (bus.BTN_START) begin
          state_nxt = ST_PAUSE;
        end else if (cnt_zero) begin
          // Unreachable in normal use; never let RUN wrap through 00:00.
          state_nxt = ST_ALARM;
          alm_load  = 1'b1;
        end else if (bus.TICK) begin
          cnt_dec = 1'b1;
          if (cnt_q == MMSS_ONE) begin
            state_nxt = ST_ALARM;
            alm_load  = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.BTN_STOP) begin
          state_nxt = ST_IDLE;
          cnt_load  = 1'b1;
        end else if (bus.BTN_START) begin
          state_nxt = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (bus.BTN_START || bus.BTN_STOP) begin
          state_nxt = ST_IDLE;
        end else if (bus.TICK) begin
          if (alm_q <= AW'(1)) state_nxt = ST_IDLE;
          else                 alm_dec   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so the registered outputs
  // reflect an input one clock after it is sampled.
  always_comb begin
    blink_nxt = 1'b0;
    if ((state_nxt == ST_PAUSE || state_nxt == ST_ALARM) && state_nxt == state_q)
      blink_nxt = bus.BLINK ^ bus.TICK;
    case (state_nxt)
      ST_IDLE:           digits_nxt = pre_nxt;
      ST_RUN, ST_PAUSE:  digits_nxt = cnt_nxt;
      default:           digits_nxt = MMSS_ZERO;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= ST_IDLE;
      alm_q       <= '0;
      bus.DIGITS  <= PRESET_DEFAULT;
      bus.BLINK   <= 1'b0;
      bus.RUNNING <= 1'b0;
      bus.DONE    <= 1'b0;
    end else if (bus.CE) begin
      state_q     <= state_nxt;
      if (alm_load)     alm_q <= AW'(ALARM_TICKS);
      else if (alm_dec) alm_q <= alm_q - AW'(1);
      bus.DIGITS  <= digits_nxt;
      bus.BLINK   <= blink_nxt;
      bus.RUNNING <= (state_nxt == ST_RUN);
      bus.DONE    <= (state_nxt == ST_ALARM);
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

  typedef struct packed {
    logic clr, ce, tick, start, stop, up, down;
  } stim_t;

  typedef struct packed {
    logic [15:0] digits;
    logic        blink, running, done;
  } obs_t;

  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  countdown_ctrl_if bus();

  countdown_ctrl #(.ALARM_TICKS(10), .PRESET_DEFAULT(16'h0100)) dut (
    .CLK(CLK), .CLR(CLR), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  stim_t pend_s[$];
  obs_t  pend_e[$];
  obs_t  sb[$];

  localparam stim_t IDLE_IN = '{clr:1'b0, ce:1'b1, tick:1'b0, start:1'b0,
                                stop:1'b0, up:1'b0, down:1'b0};

  function automatic logic [15:0] bcd(int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic stim_t mk_s(bit clr, bit ce, bit tick, bit start, bit stop, bit up, bit down);
    stim_t s;
    s = '{clr:clr, ce:ce, tick:tick, start:start, stop:stop, up:up, down:down};
    return s;
  endfunction

  function automatic obs_t mk_e(logic [15:0] d, bit blink, bit running, bit done);
    obs_t e;
    e = '{digits:d, blink:blink, running:running, done:done};
    return e;
  endfunction

  task automatic add(input stim_t s, input obs_t e);
    pend_s.push_back(s);
    pend_e.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    CLR           = s.clr;
    bus.CE        = s.ce;
    bus.TICK      = s.tick;
    bus.BTN_START = s.start;
    bus.BTN_STOP  = s.stop;
    bus.BTN_UP    = s.up;
    bus.BTN_DOWN  = s.down;
    @(posedge CLK);
    #1;
    CLR           = IDLE_IN.clr;
    bus.CE        = IDLE_IN.ce;
    bus.TICK      = 1'b0;
    bus.BTN_START = 1'b0;
    bus.BTN_STOP  = 1'b0;
    bus.BTN_UP    = 1'b0;
    bus.BTN_DOWN  = 1'b0;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{digits:bus.DIGITS, blink:bus.BLINK, running:bus.RUNNING, done:bus.DONE};
    return o;
  endfunction

  task automatic test_reset();
    obs_t got, exp;
    add(mk_s(1,1,0,0,0,0,0), mk_e(16'h0100,0,0,0));
    add(mk_s(1,0,1,1,0,0,0), mk_e(16'h0100,0,0,0));
    add(mk_s(0,1,0,0,0,0,0), mk_e(16'h0100,0,0,0));
    for (int i = 0; i < pend_s.size(); i++) begin
      sb.push_back(pend_e[i]);
      drive(pend_s[i]);
      got = sample();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp)
        $display("FAIL reset[%0d]: got digits=%h blink=%b run=%b done=%b, want digits=%h blink=%b run=%b done=%b",
                 i, got.digits, got.blink, got.running, got.done, exp.digits, exp.blink, exp.running, exp.done);
      else n_pass++;
    end
    pend_s.delete(); pend_e.delete();
  endtask

  task automatic test_countdown();
    obs_t got, exp;
    add(mk_s(0,1,0,1,0,0,0), mk_e(16'h0100,0,1,0));
    for (int k = 1; k <= 60; k++) begin
      if (k < 60) add(mk_s(0,1,1,0,0,0,0), mk_e(bcd(60 - k),0,1,0));
      else        add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0000,0,0,1));
    end
    for (int i = 0; i < pend_s.size(); i++) begin
      sb.push_back(pend_e[i]);
      drive(pend_s[i]);
      got = sample();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp)
        $display("FAIL countdown[%0d]: got digits=%h blink=%b run=%b done=%b, want digits=%h blink=%b run=%b done=%b",
                 i, got.digits, got.blink, got.running, got.done, exp.digits, exp.blink, exp.running, exp.done);
      else n_pass++;
    end
    pend_s.delete(); pend_e.delete();
  endtask

  task automatic test_alarm_timeout();
    obs_t got, exp;
    add(mk_s(0,0,1,1,1,0,0), mk_e(16'h0000,0,0,1));
    add(mk_s(0,1,0,0,0,0,0), mk_e(16'h0000,0,0,1));
    for (int k = 1; k <= 10; k++) begin
      if (k < 10) add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0000,(k % 2) == 1,0,1));
      else        add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0100,0,0,0));
    end
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0100,0,0,0));
    for (int i = 0; i < pend_s.size(); i++) begin
      sb.push_back(pend_e[i]);
      drive(pend_s[i]);
      got = sample();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp)
        $display("FAIL alarm[%0d]: got digits=%h blink=%b run=%b done=%b, want digits=%h blink=%b run=%b done=%b",
                 i, got.digits, got.blink, got.running, got.done, exp.digits, exp.blink, exp.running, exp.done);
      else n_pass++;
    end
    pend_s.delete(); pend_e.delete();
  endtask

  task automatic test_preset_wrap();
    obs_t got, exp;
    for (int k = 1; k <= 60; k++) add(mk_s(0,1,0,0,0,0,1), mk_e(bcd(60 - k),0,0,0));
    add(mk_s(0,1,0,0,0,0,1), mk_e(16'h9959,0,0,0));
    add(mk_s(0,1,0,0,0,1,0), mk_e(16'h0000,0,0,0));
    add(mk_s(0,1,0,0,0,1,1), mk_e(16'h0000,0,0,0));
    add(mk_s(0,1,0,1,0,0,0), mk_e(16'h0000,0,0,0));
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0000,0,0,0));
    for (int k = 1; k <= 600; k++) add(mk_s(0,1,0,0,0,1,0), mk_e(bcd(k),0,0,0));
    for (int i = 0; i < pend_s.size(); i++) begin
      sb.push_back(pend_e[i]);
      drive(pend_s[i]);
      got = sample();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp)
        $display("FAIL preset[%0d]: got digits=%h blink=%b run=%b done=%b, want digits=%h blink=%b run=%b done=%b",
                 i, got.digits, got.blink, got.running, got.done, exp.digits, exp.blink, exp.running, exp.done);
      else n_pass++;
    end
    pend_s.delete(); pend_e.delete();
  endtask

  task automatic test_pause();
    obs_t got, exp;
    add(mk_s(0,1,0,1,0,0,0), mk_e(16'h1000,0,1,0));
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0959,0,1,0));
    add(mk_s(0,1,0,1,0,0,0), mk_e(16'h0959,0,0,0));
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0959,1,0,0));
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0959,0,0,0));
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0959,1,0,0));
    add(mk_s(0,1,0,0,0,0,0), mk_e(16'h0959,1,0,0));
    add(mk_s(0,1,0,1,0,0,0), mk_e(16'h0959,0,1,0));
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0958,0,1,0));
    add(mk_s(0,1,0,0,0,1,0), mk_e(16'h0958,0,1,0));
    add(mk_s(0,1,1,1,0,0,0), mk_e(16'h0958,0,0,0));
    add(mk_s(0,1,0,0,0,0,1), mk_e(16'h0958,0,0,0));
    add(mk_s(0,1,0,0,1,0,0), mk_e(16'h1000,0,0,0));
    for (int i = 0; i < pend_s.size(); i++) begin
      sb.push_back(pend_e[i]);
      drive(pend_s[i]);
      got = sample();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp)
        $display("FAIL pause[%0d]: got digits=%h blink=%b run=%b done=%b, want digits=%h blink=%b run=%b done=%b",
                 i, got.digits, got.blink, got.running, got.done, exp.digits, exp.blink, exp.running, exp.done);
      else n_pass++;
    end
    pend_s.delete(); pend_e.delete();
  endtask

  task automatic test_start_stop();
    obs_t got, exp;
    add(mk_s(0,1,0,1,0,0,0), mk_e(16'h1000,0,1,0));
    add(mk_s(0,1,1,1,1,0,0), mk_e(16'h1000,0,0,0));
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h1000,0,0,0));
    for (int i = 0; i < pend_s.size(); i++) begin
      sb.push_back(pend_e[i]);
      drive(pend_s[i]);
      got = sample();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp)
        $display("FAIL start_stop[%0d]: got digits=%h blink=%b run=%b done=%b, want digits=%h blink=%b run=%b done=%b",
                 i, got.digits, got.blink, got.running, got.done, exp.digits, exp.blink, exp.running, exp.done);
      else n_pass++;
    end
    pend_s.delete(); pend_e.delete();
  endtask

  task automatic test_clr_mid_run();
    obs_t got, exp;
    add(mk_s(0,1,0,1,0,0,0), mk_e(16'h1000,0,1,0));
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0959,0,1,0));
    add(mk_s(0,0,0,0,0,0,0), mk_e(16'h0959,0,1,0));
    add(mk_s(1,0,1,0,0,0,0), mk_e(16'h0100,0,0,0));
    add(mk_s(0,1,0,0,0,0,0), mk_e(16'h0100,0,0,0));
    add(mk_s(0,1,1,0,0,0,0), mk_e(16'h0100,0,0,0));
    for (int i = 0; i < pend_s.size(); i++) begin
      sb.push_back(pend_e[i]);
      drive(pend_s[i]);
      got = sample();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp)
        $display("FAIL clr_mid_run[%0d]: got digits=%h blink=%b run=%b done=%b, want digits=%h blink=%b run=%b done=%b",
                 i, got.digits, got.blink, got.running, got.done, exp.digits, exp.blink, exp.running, exp.done);
      else n_pass++;
    end
    pend_s.delete(); pend_e.delete();
  endtask

  initial begin
    CLR           = 1'b1;
    bus.CE        = 1'b1;
    bus.TICK      = 1'b0;
    bus.BTN_START = 1'b0;
    bus.BTN_STOP  = 1'b0;
    bus.BTN_UP    = 1'b0;
    bus.BTN_DOWN  = 1'b0;
    test_reset();
    test_countdown();
    test_alarm_timeout();
    test_preset_wrap();
    test_pause();
    test_start_stop();
    test_clr_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter ALARM_TICKS, default 10, number of TICK pulses DONE stays asserted before auto-return to IDLE.
REQ-002 Parameter PRESET_DEFAULT, default 16'h0100, BCD MM:SS preset after reset (01:00).
REQ-003 CLK  in  1  sole clock; all logic on rising edge.
REQ-004 CLR  in  1  reset, synchronous, active-high.
REQ-005 CE  in  1  clock enable; when 0, all state and outputs hold.
REQ-006 TICK  in  1  one-cycle 1 s enable from the prescaler.
REQ-007 BTN_START  in  1  one-cycle debounced pulse: start/pause/resume.
REQ-008 BTN_STOP  in  1  one-cycle debounced pulse: abort/acknowledge.
REQ-009 BTN_UP  in  1  one-cycle pulse (auto-repeat allowed): preset +1 s.
REQ-010 BTN_DOWN  in  1  one-cycle pulse: preset -1 s.
REQ-011 DIGITS  out  16  BCD {M10,M1,S10,S1} for the 7-segment driver.
REQ-012 BLINK  out  1  1 in PAUSE and ALARM, toggled each TICK; else 0.
REQ-013 RUNNING  out  1  1 only in RUN.
REQ-014 DONE  out  1  1 only in ALARM.

Function
REQ-015 States IDLE, RUN, PAUSE, ALARM; all inputs ignored when CE=0.
REQ-016 IDLE: DIGITS = preset; UP/DOWN adjust preset by 1 s; seconds wrap 59->00 with minute carry; 99:59+1 -> 00:00, 00:00-1 -> 99:59.
REQ-017 UP and DOWN in the same cycle: no change.
REQ-018 IDLE + START with preset != 00:00 -> RUN, counter loaded with preset; with preset == 00:00 the START is ignored.
REQ-019 RUN: each TICK decrements counter by 1 s; S1 borrow 0->9, S10 borrow 0->5, minute decrement on SS 00->59.
REQ-020 RUN: counter reaching 00:00 -> ALARM in the same cycle the decrement is registered.
REQ-021 RUN + START -> PAUSE; PAUSE + START -> RUN; counter unchanged by the transition.
REQ-022 RUN or PAUSE + STOP -> IDLE, counter discarded, preset retained.
REQ-023 STOP has priority over START in the same cycle.
REQ-024 A TICK coinciding with a state-leaving button in RUN is dropped; otherwise applied.
REQ-025 UP/DOWN are ignored outside IDLE.
REQ-026 ALARM: DIGITS = 00:00, DONE=1; any of START/STOP, or ALARM_TICKS TICKs, -> IDLE.
REQ-027 All outputs registered; response visible one CLK after the causing input.
REQ-028 BLINK phase cleared on entry to PAUSE/ALARM (first TICK sets it to 1).

Reset
REQ-029 CLR=1 (regardless of CE): state IDLE, preset = PRESET_DEFAULT, counter = 0, alarm tick count 0.
REQ-030 Outputs in reset cycle+1: DIGITS=PRESET_DEFAULT, BLINK=0, RUNNING=0, DONE=0.
REQ-031 CLR mid-RUN/ALARM discards the countdown with no residual pulse.

Structure
REQ-032 Shared package holds the state enumeration, BCD MM:SS max constants (9,5,9,9) and the 00:00 constant.
REQ-033 One sub-module, mmss_bcd_cnt: 16-bit BCD MM:SS register with load, inc, dec, wrap and zero flag, used for both preset and counter.
REQ-034 No arithmetic on binary seconds; all arithmetic is per-digit BCD.

Verification
REQ-035 Reset, then START, 60 TICKs -> DIGITS walks 01:00, 00:59 ... 00:00; DONE=1 after the 60th TICK.
REQ-036 IDLE at 00:00, DOWN -> 99:59; UP -> 00:00; START at 00:00 -> stays IDLE, RUNNING=0.
REQ-037 RUN at 10:00, TICK -> 09:59; START -> PAUSE, 3 TICKs -> DIGITS 09:59 held, BLINK 1,0,1.
REQ-038 RUN, START and STOP in the same cycle -> IDLE, DIGITS = preset.
REQ-039 ALARM, no buttons, ALARM_TICKS=10 TICKs -> IDLE after the 10th, DONE=0, DIGITS = preset.
REQ-040 CLR asserted mid-RUN with CE=0 -> IDLE, DIGITS=01:00 next cycle.
